pc_sequencer: RTL and testbench

//  Program-counter sequencer for the datapath; owns the PC register.
//  - Produces the PC that feeds the PC leg of the 2:1 operand mux, which zero-extends it to 16 bits.
//  - Advances the PC by increment, relative branch, absolute jump, or call/return.
//  - Call/return uses a small internal return-address stack.
//  - RUN/HALTED FSM lets control freeze fetch.

---
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, a small return-address stack and a
// RUN/HALTED control FSM. All outputs are registered.
module pc_sequencer #(
   parameter int          PC_WIDTH    = 5,
   parameter int          STACK_DEPTH = 4,
   parameter int unsigned RESET_PC    = 0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                halt,
   input  logic                resume,
   input  logic                jump,
   input  logic                branch_taken,
   input  logic                call,
   input  logic                ret,
   input  logic [PC_WIDTH-1:0] target,
   input  logic [PC_WIDTH-1:0] offset,
   output logic [PC_WIDTH-1:0] pc,
   output logic                halted,
   output logic [2:0]          stack_depth,
   output logic                stack_err
);

   localparam int AW = $clog2(STACK_DEPTH);
   localparam int CW = $clog2(STACK_DEPTH) + 1;
   localparam logic [CW-1:0]       FULL  = CW'(STACK_DEPTH);
   localparam logic [PC_WIDTH-1:0] ONE   = PC_WIDTH'(1);
   localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);

   typedef enum logic {RUN, HALTED} state_t;

   state_t              state;
   logic [CW-1:0]       count;
   logic [CW-1:0]       count_m1;
   logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] stack_top;
   logic                stack_empty;
   logic                stack_full;
   logic                push;

   assign stack_depth = 3'(count);

   always_comb begin
      count_m1    = count - CW'(1);
      pc_inc      = pc + ONE;
      stack_top   = stack_mem[count_m1[AW-1:0]];
      stack_empty = (count == '0);
      stack_full  = (count == FULL);
      // A push only happens when call wins the priority chain in an active RUN cycle.
      push = !stall && (state == RUN) && !halt && !ret && call && !stack_full;
   end

   // NOTE: stack entries are don't-care after reset, so the array has no reset
   // and stays a plain memory; only the depth counter is reset.
   always_ff @(posedge clock) begin
      if (push) stack_mem[count[AW-1:0]] <= pc_inc;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of its neighbours.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         halted    <= 1'b0;
         pc        <= PC_RST;
         count     <= '0;
         stack_err <= 1'b0;
      end else begin
         stack_err <= 1'b0;
         if (!stall) begin
            case (state)
               RUN: begin
                  if (halt) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end else if (ret) begin
                     if (!stack_empty) begin
                        pc    <= stack_top;
                        count <= count_m1;
                     end else begin
                        pc        <= pc_inc;
                        stack_err <= 1'b1;
                     end
                  end else if (call) begin
                     if (!stack_full) begin
                        pc    <= target;
                        count <= count + CW'(1);
                     end else begin
                        pc        <= pc_inc;
                        stack_err <= 1'b1;
                     end
                  end else if (jump) begin
                     pc <= target;
                  end else if (branch_taken) begin
                     // Two's-complement add wraps naturally modulo 2^PC_WIDTH.
                     pc <= pc + offset;
                  end else begin
                     pc <= pc_inc;
                  end
               end
               HALTED: begin
                  if (resume && !halt) begin
                     state  <= RUN;
                     halted <= 1'b0;
                  end
               end
               default: begin
                  state  <= RUN;
                  halted <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// multi-cycle sequences, async reset check and a randomized model comparison.
module tb_pc_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       stall = 1'b0, halt = 1'b0, resume = 1'b0, jump = 1'b0;
   logic       branch_taken = 1'b0, call = 1'b0, ret = 1'b0;
   logic [4:0] target = '0, offset = '0;
   logic [4:0] pc;
   logic       halted;
   logic [2:0] stack_depth;
   logic       stack_err;

   int n_checks = 0;
   int n_errors = 0;

   pc_sequencer #(.PC_WIDTH(5), .STACK_DEPTH(4), .RESET_PC(0)) dut (
      .clock(clock), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
      .jump(jump), .branch_taken(branch_taken), .call(call), .ret(ret),
      .target(target), .offset(offset), .pc(pc), .halted(halted),
      .stack_depth(stack_depth), .stack_err(stack_err)
   );

   always #5 clock = ~clock;

   // Control bits: {stall, halt, resume, jump, branch_taken, call, ret}
   localparam logic [6:0] S  = 7'b1000000;
   localparam logic [6:0] H  = 7'b0100000;
   localparam logic [6:0] RS = 7'b0010000;
   localparam logic [6:0] J  = 7'b0001000;
   localparam logic [6:0] B  = 7'b0000100;
   localparam logic [6:0] C  = 7'b0000010;
   localparam logic [6:0] RT = 7'b0000001;
   localparam logic [6:0] NO = 7'b0000000;

   typedef struct {
      logic [6:0] ctl;
      logic [4:0] tgt;
      logic [4:0] off;
      logic [4:0] pc;
      logic       halted;
      logic [2:0] depth;
      logic       err;
   } vec_t;

   vec_t tbl[$];
   int   vec_no = 0;

   function automatic vec_t v(input logic [6:0] ctl, input int tgt, input int off,
                              input int epc, input bit eh, input int ed, input bit ee);
      vec_t r;
      r.ctl = ctl; r.tgt = 5'(tgt); r.off = 5'(off);
      r.pc = 5'(epc); r.halted = eh; r.depth = 3'(ed); r.err = ee;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] ctl, input logic [4:0] tgt, input logic [4:0] off);
      {stall, halt, resume, jump, branch_taken, call, ret} = ctl;
      target = tgt;
      offset = off;
   endtask

   task automatic apply(input vec_t x);
      drive(x.ctl, x.tgt, x.off);
      @(posedge clock);
      #1;
      vec_no++;
      check($sformatf("v%0d.pc", vec_no), 32'(pc), 32'(x.pc));
      check($sformatf("v%0d.halted", vec_no), 32'(halted), 32'(x.halted));
      check($sformatf("v%0d.depth", vec_no), 32'(stack_depth), 32'(x.depth));
      check($sformatf("v%0d.err", vec_no), 32'(stack_err), 32'(x.err));
   endtask

   // Behavioural reference for the random phase.
   int m_pc;
   bit m_halted;
   bit m_err;
   int m_stack[$];

   task automatic model_step(input logic [6:0] ctl, input int tgt, input int off);
      bit s, h, rs, jp, br, cl, rt;
      int soff;
      {s, h, rs, jp, br, cl, rt} = ctl;
      m_err = 0;
      if (s) return;
      if (m_halted) begin
         if (rs && !h) m_halted = 0;
         return;
      end
      soff = (off >= 16) ? off - 32 : off;
      if (h) m_halted = 1;
      else if (rt) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else begin m_pc = (m_pc + 1) % 32; m_err = 1; end
      end else if (cl) begin
         if (m_stack.size() < 4) begin
            m_stack.push_back((m_pc + 1) % 32);
            m_pc = tgt;
         end else begin m_pc = (m_pc + 1) % 32; m_err = 1; end
      end else if (jp) m_pc = tgt;
      else if (br) m_pc = (m_pc + soff + 32) % 32;
      else m_pc = (m_pc + 1) % 32;
   endtask

   initial begin
      #12 reset = 1'b0;
      #1;
      check("reset.pc", 32'(pc), 0);
      check("reset.halted", 32'(halted), 0);
      check("reset.depth", 32'(stack_depth), 0);
      check("reset.err", 32'(stack_err), 0);

      tbl.push_back(v(NO, 0, 0, 1, 0, 0, 0));
      tbl.push_back(v(NO, 0, 0, 2, 0, 0, 0));
      tbl.push_back(v(NO, 0, 0, 3, 0, 0, 0));
      tbl.push_back(v(NO, 0, 0, 4, 0, 0, 0));
      tbl.push_back(v(C, 20, 0, 20, 0, 1, 0));
      tbl.push_back(v(RT, 0, 0, 5, 0, 0, 0));
      tbl.push_back(v(RT, 0, 0, 6, 0, 0, 1));
      tbl.push_back(v(NO, 0, 0, 7, 0, 0, 0));
      tbl.push_back(v(J, 2, 0, 2, 0, 0, 0));
      tbl.push_back(v(B, 0, 29, 31, 0, 0, 0));
      tbl.push_back(v(NO, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(S | J, 9, 0, 0, 0, 0, 0));
      tbl.push_back(v(C | J, 30, 0, 30, 0, 1, 0));
      tbl.push_back(v(RT | C, 12, 0, 1, 0, 0, 0));
      tbl.push_back(v(H | J, 9, 0, 1, 1, 0, 0));
      tbl.push_back(v(J, 9, 0, 1, 1, 0, 0));
      tbl.push_back(v(RT, 0, 0, 1, 1, 0, 0));
      tbl.push_back(v(RS | H, 0, 0, 1, 1, 0, 0));
      tbl.push_back(v(RS, 0, 0, 1, 0, 0, 0));
      tbl.push_back(v(NO, 0, 0, 2, 0, 0, 0));
      tbl.push_back(v(S | H, 0, 0, 2, 0, 0, 0));
      tbl.push_back(v(B, 0, 3, 5, 0, 0, 0));
      tbl.push_back(v(S | RT, 0, 0, 5, 0, 0, 0));
      foreach (tbl[i]) apply(tbl[i]);

      // Fill the stack, overflow it at pc=9, then unwind it.
      apply(v(J, 5, 0, 5, 0, 0, 0));
      apply(v(C, 11, 0, 11, 0, 1, 0));
      apply(v(C, 13, 0, 13, 0, 2, 0));
      apply(v(C, 15, 0, 15, 0, 3, 0));
      apply(v(C, 8, 0, 8, 0, 4, 0));
      apply(v(NO, 0, 0, 9, 0, 4, 0));
      apply(v(C, 25, 0, 10, 0, 4, 1));
      apply(v(NO, 0, 0, 11, 0, 4, 0));
      apply(v(RT, 0, 0, 16, 0, 3, 0));
      apply(v(RT, 0, 0, 14, 0, 2, 0));
      apply(v(RT, 0, 0, 12, 0, 1, 0));
      apply(v(RT, 0, 0, 6, 0, 0, 0));
      // Underflow at pc=7, then a call at pc=31 pushing 0.
      apply(v(J, 7, 0, 7, 0, 0, 0));
      apply(v(RT, 0, 0, 8, 0, 0, 1));
      apply(v(J, 31, 0, 31, 0, 0, 0));
      apply(v(C, 3, 0, 3, 0, 1, 0));
      apply(v(RT, 0, 0, 0, 0, 0, 0));
      // Halt at pc=6, ignore requests while halted, resume.
      apply(v(J, 6, 0, 6, 0, 0, 0));
      apply(v(H, 0, 0, 6, 1, 0, 0));
      apply(v(J, 20, 0, 6, 1, 0, 0));
      apply(v(C, 20, 0, 6, 1, 0, 0));
      apply(v(RS, 0, 0, 6, 0, 0, 0));
      apply(v(NO, 0, 0, 7, 0, 0, 0));
      apply(v(C, 20, 0, 20, 0, 1, 0));

      // Asynchronous reset mid-cycle while a call is outstanding.
      drive(NO, 0, 0);
      #3 reset = 1'b1;
      #1;
      check("async.pc", 32'(pc), 0);
      check("async.depth", 32'(stack_depth), 0);
      check("async.halted", 32'(halted), 0);
      #2 reset = 1'b0;

      m_pc = 0; m_halted = 0; m_err = 0; m_stack.delete();
      for (int i = 0; i < 400; i++) begin
         logic [6:0] ctl;
         logic [4:0] tg, of;
         ctl[6] = ($urandom_range(0, 9) == 0);
         ctl[5] = ($urandom_range(0, 19) == 0);
         ctl[4] = ($urandom_range(0, 4) == 0);
         ctl[3] = ($urandom_range(0, 6) == 0);
         ctl[2] = ($urandom_range(0, 4) == 0);
         ctl[1] = ($urandom_range(0, 3) == 0);
         ctl[0] = ($urandom_range(0, 3) == 0);
         tg = 5'($urandom_range(0, 31));
         of = 5'($urandom_range(0, 31));
         drive(ctl, tg, of);
         model_step(ctl, int'(tg), int'(of));
         @(posedge clock);
         #1;
         check($sformatf("rnd%0d.pc", i), 32'(pc), 32'(m_pc));
         check($sformatf("rnd%0d.halted", i), 32'(halted), 32'(m_halted));
         check($sformatf("rnd%0d.depth", i), 32'(stack_depth), 32'(m_stack.size()));
         check($sformatf("rnd%0d.err", i), 32'(stack_err), 32'(m_err));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
